// File: rtl/pll_rst_seq.sv
// pll_rst_seq: consumer-side PLL supervisory sequencer.
// It pulses the PLL reset and waits for the PLL to lock. Lock only counts once
// it has stayed up for a set number of cycles. If lock does not arrive in time,
// the PLL is reset again. After the allowed number of retries the sequencer
// parks in FAIL with the PLL powered down. Downstream logic gets a stretched
// synchronous reset that is released only after lock is qualified.
// Runs on the free-running reference clock. rst_n is synchronous, active-low.
//
// Optional build macro: PLL_RST_SEQ_LOSS_FILT_EN
//   Defined   : in RUN, lock must read low for LOSS_FILT_CYC consecutive
//               cycles before the loss is acted on.
//   Undefined : a single low cycle of synchronized lock in RUN is a loss.

module pll_rst_seq #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 100000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int RST_HOLD_CYC     = 64,
    parameter int MAX_RETRY        = 3,
    parameter int LOSS_FILT_CYC    = 8,
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock_i,
    input  logic               relock_req_i,
    output logic               pll_rst_o,
    output logic               pll_pwd_o,
    output logic               sys_rst_n_o,
    output logic [2:0]         state_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic               lock_lost_o,
    output logic               fail_o
);

    // RESET and HOLD share one phase counter, so it is sized for the longer
    // of the two phases.
    localparam int PHASE_MAX = (RST_PULSE_CYC > RST_HOLD_CYC) ? RST_PULSE_CYC : RST_HOLD_CYC;
    localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int TMO_W     = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int STB_W     = $clog2(LOCK_STABLE_CYC + 1);

    localparam logic [PHASE_W-1:0] PULSE_LAST = PHASE_W'(RST_PULSE_CYC - 1);
    localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(RST_HOLD_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_SAT    = TMO_W'(LOCK_TIMEOUT_CYC);
    localparam logic [STB_W-1:0]   STB_LAST   = STB_W'(LOCK_STABLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [STB_W-1:0]     stable_q, stable_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 lost_q, lost_d;
    logic                 lock_meta;
    logic                 lock_s;
    logic                 retry_ok;
    logic                 tmo_hit;
    state_t               tmo_state;
    logic [RETRY_W-1:0]   tmo_retry;
    logic [TMO_W-1:0]     tmo_inc;

`ifdef PLL_RST_SEQ_LOSS_FILT_EN
    localparam int FILT_W = $clog2(LOSS_FILT_CYC + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILT_CYC - 1);

    logic [FILT_W-1:0]    filt_q, filt_d;
`else
    // The filter length only matters when the loss filter is built in.
    logic [31:0]          unused_loss_filt;
    assign unused_loss_filt = LOSS_FILT_CYC;
`endif

    // The timeout outcome is the same from WAIT_LOCK and STABLE. Either
    // retry through RESET with one more failed attempt, or give up in FAIL.
    assign retry_ok  = int'(retry_q) < MAX_RETRY;
    assign tmo_hit   = (tmo_q == TMO_LAST);
    assign tmo_state = retry_ok ? ST_RESET : ST_FAIL;
    assign tmo_retry = retry_ok ? retry_q + RETRY_W'(1) : retry_q;
    // The timeout counter saturates instead of wrapping.
    assign tmo_inc   = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + TMO_W'(1);

    // Two-flop synchronizer for the asynchronous PLL lock; only lock_s is used below.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock_i;
            lock_s    <= lock_meta;
        end
    end

    // Next-state and counter logic; a relock request overrides everything else.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        tmo_d    = tmo_q;
        stable_d = stable_q;
        retry_d  = retry_q;
        lost_d   = lost_q;
`ifdef PLL_RST_SEQ_LOSS_FILT_EN
        filt_d   = '0;
`endif

        if (relock_req_i) begin
            state_d = ST_RESET;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (phase_q == PULSE_LAST) begin
                        state_d  = ST_WAIT_LOCK;
                        tmo_d    = '0;
                        stable_d = '0;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end

                ST_WAIT_LOCK: begin
                    tmo_d = tmo_inc;
                    if (tmo_hit) begin
                        state_d = tmo_state;
                        retry_d = tmo_retry;
                    end else if (lock_s) begin
                        stable_d = STB_W'(1);
                        state_d  = (LOCK_STABLE_CYC == 1) ? ST_HOLD : ST_STABLE;
                    end
                end

                ST_STABLE: begin
                    tmo_d = tmo_inc;
                    if (tmo_hit) begin
                        state_d = tmo_state;
                        retry_d = tmo_retry;
                    end else if (!lock_s) begin
                        state_d  = ST_WAIT_LOCK;
                        stable_d = '0;
                    end else if (stable_q == STB_LAST) begin
                        state_d = ST_HOLD;
                    end else begin
                        stable_d = stable_q + STB_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (!lock_s) begin
                        state_d = ST_RESET;
                    end else if (phase_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end

                ST_RUN: begin
`ifdef PLL_RST_SEQ_LOSS_FILT_EN
                    if (lock_s) begin
                        filt_d = '0;
                    end else if (filt_q == FILT_LAST) begin
                        lost_d  = 1'b1;
                        state_d = ST_RESET;
                    end else begin
                        filt_d = filt_q + FILT_W'(1);
                    end
`else
                    if (!lock_s) begin
                        lost_d  = 1'b1;
                        state_d = ST_RESET;
                    end
`endif
                end

                ST_FAIL: begin
                    state_d = ST_FAIL;
                end

                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end

        // Every phase starts counting from zero, including a restarted RESET.
        if ((state_d != state_q) || relock_req_i) begin
            phase_d = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RESET;
            phase_q  <= '0;
            tmo_q    <= '0;
            stable_q <= '0;
            retry_q  <= '0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            tmo_q    <= tmo_d;
            stable_q <= stable_d;
            retry_q  <= retry_d;
            lost_q   <= lost_d;
        end
    end

`ifdef PLL_RST_SEQ_LOSS_FILT_EN
    // Consecutive-low counter for the RUN lock-loss filter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt_d;
        end
    end
`endif

    // Output flops decode the next state, so each output changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pll_rst_o   <= 1'b1;
            pll_pwd_o   <= 1'b0;
            sys_rst_n_o <= 1'b0;
            fail_o      <= 1'b0;
        end else begin
            pll_rst_o   <= (state_d == ST_RESET) || (state_d == ST_FAIL);
            pll_pwd_o   <= (state_d == ST_FAIL);
            sys_rst_n_o <= (state_d == ST_RUN);
            fail_o      <= (state_d == ST_FAIL);
        end
    end

    assign state_o     = state_q;
    assign retry_cnt_o = retry_q;
    assign lock_lost_o = lost_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: self-checking bench for pll_rst_seq.
// A behavioural model checks the DUT on every cycle. Directed scenarios cover
// nominal bring-up, STABLE chatter with timeout, lock loss, FAIL and recovery,
// and mid-sequence reset. A randomized soak follows.
// Honours PLL_RST_SEQ_LOSS_FILT_EN in step with the design.

module tb_pll_rst_seq;

    localparam int P  = 4;
    localparam int T  = 50;
    localparam int L  = 8;
    localparam int H  = 5;
    localparam int MR = 2;
    localparam int F  = 8;
    localparam int RW = $clog2(MR + 1);
`ifdef PLL_RST_SEQ_LOSS_FILT_EN
    localparam int LOSS_LEN = F;
`else
    localparam int LOSS_LEN = 1;
`endif

    // Model phases: the reference sees one "waiting" phase covering WAIT_LOCK and STABLE.
    localparam int M_PULSE = 0;
    localparam int M_WAIT  = 1;
    localparam int M_HOLD  = 2;
    localparam int M_RUN   = 3;
    localparam int M_FAIL  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pll_lock_i;
    logic          relock_req_i;
    logic          pll_rst_o;
    logic          pll_pwd_o;
    logic          sys_rst_n_o;
    logic [2:0]    state_o;
    logic [RW-1:0] retry_cnt_o;
    logic          lock_lost_o;
    logic          fail_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cnt;
    int dly;
    logic rnd_lock;

    int m_phase, m_age, m_since, m_run, m_lowrun, m_retry;
    bit m_lost, m_ls;
    bit m_sync[$];

    pll_rst_seq #(
        .RST_PULSE_CYC   (P),
        .LOCK_TIMEOUT_CYC(T),
        .LOCK_STABLE_CYC (L),
        .RST_HOLD_CYC    (H),
        .MAX_RETRY       (MR),
        .LOSS_FILT_CYC   (F)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock_i  (pll_lock_i),
        .relock_req_i(relock_req_i),
        .pll_rst_o   (pll_rst_o),
        .pll_pwd_o   (pll_pwd_o),
        .sys_rst_n_o (sys_rst_n_o),
        .state_o     (state_o),
        .retry_cnt_o (retry_cnt_o),
        .lock_lost_o (lock_lost_o),
        .fail_o      (fail_o)
    );

    // Free-running reference clock.
    always #5 clk = ~clk;

    // Reference model: ages, elapsed time and lock run lengths, advanced on every rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase  = M_PULSE;
            m_age    = 0;
            m_since  = 0;
            m_run    = 0;
            m_lowrun = 0;
            m_retry  = 0;
            m_lost   = 1'b0;
            m_sync   = '{1'b0, 1'b0};
        end else begin
            m_ls = m_sync.pop_front();
            m_sync.push_back(pll_lock_i);
            if (relock_req_i) begin
                m_phase = M_PULSE;
                m_age   = 0;
                m_retry = 0;
            end else begin
                case (m_phase)
                    M_PULSE: begin
                        m_age++;
                        if (m_age == P) begin
                            m_phase = M_WAIT;
                            m_since = 0;
                            m_run   = 0;
                        end
                    end
                    M_WAIT: begin
                        m_since++;
                        if (m_since == T) begin
                            if (m_retry < MR) begin
                                m_retry++;
                                m_phase = M_PULSE;
                                m_age   = 0;
                            end else begin
                                m_phase = M_FAIL;
                            end
                        end else if (m_ls) begin
                            m_run++;
                            if (m_run == L) begin
                                m_phase = M_HOLD;
                                m_age   = 0;
                            end
                        end else begin
                            m_run = 0;
                        end
                    end
                    M_HOLD: begin
                        if (!m_ls) begin
                            m_phase = M_PULSE;
                            m_age   = 0;
                        end else begin
                            m_age++;
                            if (m_age == H) begin
                                m_phase  = M_RUN;
                                m_retry  = 0;
                                m_lowrun = 0;
                            end
                        end
                    end
                    M_RUN: begin
                        if (!m_ls) begin
                            m_lowrun++;
                            if (m_lowrun >= LOSS_LEN) begin
                                m_lost  = 1'b1;
                                m_phase = M_PULSE;
                                m_age   = 0;
                            end
                        end else begin
                            m_lowrun = 0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    function automatic int expState();
        case (m_phase)
            M_PULSE: return 0;
            M_WAIT:  return (m_run > 0) ? 2 : 1;
            M_HOLD:  return 3;
            M_RUN:   return 4;
            default: return 5;
        endcase
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("state", 32'(state_o), 32'(expState()));
        checkVal("pll_rst", 32'(pll_rst_o), 32'((m_phase == M_PULSE) || (m_phase == M_FAIL)));
        checkVal("pll_pwd", 32'(pll_pwd_o), 32'(m_phase == M_FAIL));
        checkVal("sys_rst_n", 32'(sys_rst_n_o), 32'(m_phase == M_RUN));
        checkVal("fail", 32'(fail_o), 32'(m_phase == M_FAIL));
        checkVal("retry", 32'(retry_cnt_o), 32'(m_retry));
        checkVal("lock_lost", 32'(lock_lost_o), 32'(m_lost));
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, "_state"}, 32'(state_o), 32'd0);
        checkVal({tag, "_pll_rst"}, 32'(pll_rst_o), 32'd1);
        checkVal({tag, "_pll_pwd"}, 32'(pll_pwd_o), 32'd0);
        checkVal({tag, "_sys_rst_n"}, 32'(sys_rst_n_o), 32'd0);
        checkVal({tag, "_retry"}, 32'(retry_cnt_o), 32'd0);
        checkVal({tag, "_lock_lost"}, 32'(lock_lost_o), 32'd0);
        checkVal({tag, "_fail"}, 32'(fail_o), 32'd0);
    endtask

    task automatic applyStimulus(input logic r, input logic lk, input logic rq);
        rst_n        = r;
        pll_lock_i   = lk;
        relock_req_i = rq;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    // Counts cycles until pll_rst_o falls, bounded.
    task automatic measurePulse(output int n);
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (pll_rst_o !== 1'b1) break;
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset state.
        tick();
        tick();
        checkReset("reset");

        // Nominal bring-up.
        applyStimulus(1'b1, 1'b0, 1'b0);
        measurePulse(cnt);
        checkVal("bringup_pulse_len", cnt, 4);
        repeat (10) tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        cnt = 0;
        while (cnt < 40) begin
            tick();
            cnt++;
            if (sys_rst_n_o === 1'b1) break;
        end
        checkVal("bringup_sys_rst_delay", cnt, 15);
        checkVal("bringup_state", 32'(state_o), 4);
        checkVal("bringup_retry", 32'(retry_cnt_o), 0);

        // Lock loss in RUN.
`ifdef PLL_RST_SEQ_LOSS_FILT_EN
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (6) tick();
        checkVal("glitch_ignored_state", 32'(state_o), 4);
        checkVal("glitch_ignored_lost", 32'(lock_lost_o), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (9) tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        checkVal("long_drop_lost", 32'(lock_lost_o), 1);
        checkVal("long_drop_pll_rst", 32'(pll_rst_o), 1);
`else
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        cnt = 1;
        while ((sys_rst_n_o === 1'b1) && (cnt < 10)) begin
            tick();
            cnt++;
        end
        checkVal("loss_sys_rst_delay", cnt, 3);
        checkVal("loss_lost", 32'(lock_lost_o), 1);
`endif
        repeat (30) tick();
        checkVal("relock_state", 32'(state_o), 4);
        checkVal("relock_lost_sticky", 32'(lock_lost_o), 1);

        // Chatter in STABLE pushes qualification past the timeout.
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkVal("chatter_restart_state", 32'(state_o), 0);
        repeat (4) tick();
        dly = $urandom_range(36, 42);
        repeat (dly) tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (5) tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        cnt = 0;
        while (cnt < 60) begin
            tick();
            cnt++;
            if (state_o === 3'd0) break;
        end
        checkVal("chatter_timeout_state", 32'(state_o), 0);
        checkVal("chatter_retry", 32'(retry_cnt_o), 1);
        repeat (40) tick();
        checkVal("chatter_run_state", 32'(state_o), 4);
        checkVal("chatter_run_retry", 32'(retry_cnt_o), 0);

        // Lock never arrives.
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        cnt = 0;
        while (cnt < 250) begin
            tick();
            cnt++;
            if (fail_o === 1'b1) break;
        end
        checkVal("nolock_cycles_to_fail", cnt, 162);
        checkVal("nolock_state", 32'(state_o), 5);
        checkVal("nolock_pwd", 32'(pll_pwd_o), 1);
        checkVal("nolock_retry", 32'(retry_cnt_o), 2);
        checkVal("nolock_sys_rst_n", 32'(sys_rst_n_o), 0);
        repeat (10) tick();
        checkVal("fail_parked", 32'(state_o), 5);

        // Recovery from FAIL.
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkVal("recover_state", 32'(state_o), 0);
        checkVal("recover_fail", 32'(fail_o), 0);
        checkVal("recover_pwd", 32'(pll_pwd_o), 0);
        checkVal("recover_retry", 32'(retry_cnt_o), 0);
        repeat (30) tick();
        checkVal("recover_run", 32'(state_o), 4);

        // rst_n mid-RESET.
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (2) tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkReset("midreset");
        applyStimulus(1'b1, 1'b1, 1'b0);
        measurePulse(cnt);
        checkVal("midreset_pulse_len", cnt, 4);

        // rst_n mid-RUN.
        repeat (30) tick();
        checkVal("midrun_pre_state", 32'(state_o), 4);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkReset("midrun");
        applyStimulus(1'b1, 1'b1, 1'b0);
        measurePulse(cnt);
        checkVal("midrun_pulse_len", cnt, 4);

        // Randomized soak against the model.
        rnd_lock = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (rnd_lock) begin
                if ($urandom_range(0, 99) < 3) rnd_lock = 1'b0;
            end else begin
                if ($urandom_range(0, 99) < 25) rnd_lock = 1'b1;
            end
            applyStimulus(($urandom_range(0, 399) != 0), rnd_lock, ($urandom_range(0, 249) == 0));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
